bus_arbiter_rr: RTL
===================

// Module: bus_arbiter_rr
// PURPOSE
//  Parametrised round-robin bus arbiter for N bus masters; next generation of the fixed 4-master arbiter.
//  Adds a bounded-hold (anti-starvation) counter that forces rotation after MAX_HOLD cycles of contention.
//  Sits between the bus masters and the bus address/data muxes; owner drives the master-select mux.
// PARAMETERS
//  NUM_MASTERS  4                         number of masters; legal range 2..16
//  OWNER_W      $clog2(NUM_MASTERS)       width of the owner index
//  MAX_HOLD     16                        max consecutive contended cycles per owner; 0 = no limit
//  HOLD_W       $clog2(MAX_HOLD+1)        width of the hold counter (minimum 1)
// PORTS
//  clk        in   1            system clock, rising edge
//  reset      in   1            asynchronous reset, active-low
//  mReq_      in   NUM_MASTERS  bus request per master, active-low (bit i = master i)
//  mGrnt_     out  NUM_MASTERS  bus grant per master, active-low, one-hot-low
//  owner      out  OWNER_W      index of the current bus owner (registered)
//  preempt    out  1            1-cycle pulse, high in the first cycle after a forced rotation
//  mLock_     in   NUM_MASTERS  (BUS_ARB_LOCK_EN only) per-master lock, active-low
// BEHAVIOUR
//  - Reset (reset=0, async): owner=0, hold_cnt=0, preempt=0, mGrnt_ = all ones except bit0=0.
//    Master 0 is granted while reset is held.
//  - mGrnt_ is decoded combinationally from owner. Exactly one bit is low at all times.
//    The bus parks on the last owner; there is never an "idle, no grant" state.
//  - Owner update at each rising clk edge. A new grant is visible 1 cycle after the deciding edge.
//  - Search order: owner+1, owner+2, ... wraps from NUM_MASTERS-1 to 0, and stops before owner.
//    The first requesting master in that order is the "next".
//  - Case A, owner request deasserted (mReq_[owner]=1):
//    owner <= next if any other master requests; otherwise owner is unchanged.
//    hold_cnt <= 0.
//  - Case B, owner request asserted, no other request: owner unchanged; hold_cnt <= 0.
//  - Case C, owner request asserted and another request pending:
//    - If MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: owner <= next, hold_cnt <= 0, preempt <= 1.
//    - Otherwise: owner unchanged, hold_cnt <= hold_cnt+1.
//  - preempt is low in every cycle not following a forced rotation.
//  - Any owner change clears hold_cnt to 0. hold_cnt never exceeds MAX_HOLD-1 (no wrap).
//  - Owner index values >= NUM_MASTERS are unreachable, including for non-power-of-2 N.
//  - MAX_HOLD=0: Case C always keeps the owner (pure priority-hold, as in the previous generation).
//  - A master that loses the bus by preemption and keeps requesting re-enters the rotation normally.
//    It is granted again only after the search order reaches it.
//  - Reset asserted mid-operation: all state is cleared immediately, with no clock needed.
//    The first edge after reset deassertion applies the rules above from owner=0.
// CONFIGURATION
//  BUS_ARB_LOCK_EN defined:
//    - The mLock_ port exists.
//    - If mLock_[owner]=0 and mReq_[owner]=0, Case C never preempts and hold_cnt holds its value.
//    - Locks of non-owners are ignored.
//  BUS_ARB_LOCK_EN undefined:
//    - No mLock_ port.
//    - The hold limit always applies.
// TESTING (N=4, MAX_HOLD=4 unless noted)
//  1. Reset:
//     hold reset=0 with random mReq_ -> mGrnt_=4'b1110, owner=0, preempt=0.
//     After release with mReq_=4'b1111, owner stays 0.
//  2. Rotation and wrap:
//     owner=0, mReq_=4'b0101 -> owner=1 (grant 4'b1101).
//     Then mReq_=4'b0111 -> owner=3.
//     Then mReq_=4'b1110 -> owner wraps to 0.
//  3. Park: owner=2, mReq_=4'b1111 for 10 cycles -> owner=2 and mGrnt_=4'b1011 throughout.
//  4. Hold limit: master0 and master2 request continuously from owner=0.
//     -> owner=2 on the 4th edge; preempt high for exactly 1 cycle.
//     Then owner returns to 0 after 4 more contended cycles.
//  5. Lock (BUS_ARB_LOCK_EN): as test 4 with mLock_=4'b1110 -> owner stays 0 for 20 cycles; preempt=0.
//     Releasing the lock -> rotation to 2 after at most 1 edge when hold_cnt is at its limit.
//  6. Reset mid-operation: owner=2, hold_cnt=3; pulse reset low between edges.
//     -> owner=0 and mGrnt_=4'b1110 immediately; preempt=0.
//     Also rerun tests 2 and 4 with NUM_MASTERS=3 and MAX_HOLD=0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter for NUM_MASTERS masters with a bounded-hold counter that forces rotation under contention.
// Optional owner lock (mLock_ port) is enabled by defining BUS_ARB_LOCK_EN.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = $clog2(NUM_MASTERS),
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] mReq_,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0] mLock_,
`endif
  output logic [NUM_MASTERS-1:0] mGrnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   preempt
);

  typedef enum logic [1:0] {
    ARB_RELEASE,  // owner no longer requests
    ARB_SOLE,     // owner requests, nobody else does
    ARB_CONTEND   // owner requests and another master is waiting
  } arb_case_e;

  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

  logic [OWNER_W-1:0] r_owner;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_preempt;

  logic [OWNER_W-1:0] w_next;
  logic               w_other_req;
  logic               w_owner_req;
  logic               w_locked;
  arb_case_e          w_case;
  logic [OWNER_W-1:0] w_owner_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic               w_preempt_nxt;

  // Scan from the farthest candidate to the nearest so the nearest requester,
  // in owner+1, owner+2, ... order, is the last one written and wins.
  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    int idx;
    idx         = 0;
    w_next      = r_owner;
    w_other_req = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
      idx = int'(r_owner) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!mReq_[OWNER_W'(idx)]) begin
        w_next      = OWNER_W'(idx);
        w_other_req = 1'b1;
      end
    end
  end

  assign w_owner_req = ~mReq_[r_owner];

`ifdef BUS_ARB_LOCK_EN
  assign w_locked = ~mLock_[r_owner] & w_owner_req;
`else
  assign w_locked = 1'b0;
`endif

  always_comb begin
    if (!w_owner_req)     w_case = ARB_RELEASE;
    else if (w_other_req) w_case = ARB_CONTEND;
    else                  w_case = ARB_SOLE;
  end

  always_comb begin
    w_owner_nxt   = r_owner;
    w_hold_nxt    = '0;
    w_preempt_nxt = 1'b0;
    unique case (w_case)
      ARB_RELEASE: w_owner_nxt = w_next;
      ARB_SOLE:    w_owner_nxt = r_owner;
      ARB_CONTEND: begin
        if (w_locked) begin
          w_hold_nxt = r_hold;
        end else if (HOLD_EN && (r_hold == HOLD_LAST)) begin
          w_owner_nxt   = w_next;
          w_preempt_nxt = 1'b1;
        end else if (HOLD_EN) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_owner_nxt = r_owner;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner   <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_owner   <= w_owner_nxt;
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  // The bus always parks on the owner, so exactly one grant is low.
  always_comb begin
    mGrnt_          = '1;
    mGrnt_[r_owner] = 1'b0;
  end

  assign owner   = r_owner;
  assign preempt = r_preempt;

endmodule
